// File: rtl/vrased_pkg.sv
// rtl/vrased_pkg.sv - shared types and constants for the VRASED hardware guard
// FSM encoding, cause-bit positions and default memory map.
package vrased_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } vr_state_e;

  localparam int CAUSE_AC        = 0;
  localparam int CAUSE_XSTACK    = 1;
  localparam int CAUSE_ENTRY     = 2;
  localparam int CAUSE_EXIT      = 3;
  localparam int CAUSE_IRQ       = 4;
  localparam int CAUSE_DMA_KEY   = 5;
  localparam int CAUSE_DMA_STACK = 6;
  localparam int CAUSE_DMA_EXEC  = 7;

  // Region sizes are inclusive end offsets: a region spans [BASE, BASE+SIZE].
  localparam logic [15:0] DEF_SMEM_BASE     = 16'hA000;
  localparam logic [15:0] DEF_SMEM_SIZE     = 16'h4000;
  localparam logic [15:0] DEF_KMEM_BASE     = 16'h6A00;
  localparam logic [15:0] DEF_KMEM_SIZE     = 16'h001F;
  localparam logic [15:0] DEF_SDATA_BASE    = 16'h0400;
  localparam logic [15:0] DEF_SDATA_SIZE    = 16'h0C00;
  localparam logic [15:0] DEF_HMAC_BASE     = 16'h0230;
  localparam logic [15:0] DEF_HMAC_SIZE     = 16'h0020;
  localparam logic [15:0] DEF_RESET_HANDLER = 16'h0000;
  localparam int          DEF_N_DMA         = 2;
  localparam int          DEF_RST_HOLD      = 4;

endpackage

// File: rtl/vrased_range_chk.sv
// rtl/vrased_range_chk.sv - inclusive address range comparator
// The end bound is computed in 17 bits so a region touching 16'hFFFF cannot wrap.
module vrased_range_chk (
  input  logic [15:0] addr,
  input  logic [15:0] base,
  input  logic [15:0] size,
  output logic        hit
);

  logic [16:0] top;

  assign top = {1'b0, base} + {1'b0, size};
  assign hit = (addr >= base) && ({1'b0, addr} <= top);

endmodule

// File: rtl/vrased_guard.sv
// rtl/vrased_guard.sv - VRASED access/atomicity guard that forces an MCU reset
// Violations in IDLE/EXEC open an episode: a fixed HOLD window, then WAIT until the CPU is at the reset handler.
module vrased_guard
  import vrased_pkg::*;
#(
  parameter logic [15:0] SMEM_BASE     = DEF_SMEM_BASE,
  parameter logic [15:0] SMEM_SIZE     = DEF_SMEM_SIZE,
  parameter logic [15:0] SMEM_EXIT     = SMEM_BASE + SMEM_SIZE - 16'd2,
  parameter logic [15:0] KMEM_BASE     = DEF_KMEM_BASE,
  parameter logic [15:0] KMEM_SIZE     = DEF_KMEM_SIZE,
  parameter logic [15:0] SDATA_BASE    = DEF_SDATA_BASE,
  parameter logic [15:0] SDATA_SIZE    = DEF_SDATA_SIZE,
  parameter logic [15:0] HMAC_BASE     = DEF_HMAC_BASE,
  parameter logic [15:0] HMAC_SIZE     = DEF_HMAC_SIZE,
  parameter logic [15:0] RESET_HANDLER = DEF_RESET_HANDLER,
  parameter int          N_DMA         = DEF_N_DMA,
  parameter int          RST_HOLD      = DEF_RST_HOLD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          pc,
  input  logic                 data_en,
  input  logic                 data_wr,
  input  logic [15:0]          data_addr,
  input  logic [N_DMA-1:0]     dma_en,
  input  logic [16*N_DMA-1:0]  dma_addr,
  input  logic                 irq,
  output logic                 reset,
  output logic [7:0]           cause,
  output logic [N_DMA-1:0]     dma_src,
  output logic [7:0]           viol_count
);

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD - 1);

  vr_state_e        state_q, state_d;
  logic             reset_q, reset_d;
  logic [7:0]       cause_q, cause_d;
  logic [N_DMA-1:0] dma_src_q, dma_src_d;
  logic [7:0]       viol_count_q, viol_count_d;
  logic [15:0]      pc_prev_q, pc_prev_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;

  logic             in_smem, d_kmem, d_sdata, d_hmac;
  logic [N_DMA-1:0] dma_kmem, dma_sdata, dma_bad;
  logic [7:0]       viol;

  vrased_range_chk u_pc_smem  (.addr(pc),        .base(SMEM_BASE),  .size(SMEM_SIZE),  .hit(in_smem));
  vrased_range_chk u_d_kmem   (.addr(data_addr), .base(KMEM_BASE),  .size(KMEM_SIZE),  .hit(d_kmem));
  vrased_range_chk u_d_sdata  (.addr(data_addr), .base(SDATA_BASE), .size(SDATA_SIZE), .hit(d_sdata));
  vrased_range_chk u_d_hmac   (.addr(data_addr), .base(HMAC_BASE),  .size(HMAC_SIZE),  .hit(d_hmac));

  generate
    for (genvar k = 0; k < N_DMA; k++) begin : g_dma
      vrased_range_chk u_kmem  (.addr(dma_addr[16*k +: 16]), .base(KMEM_BASE),
                                .size(KMEM_SIZE),  .hit(dma_kmem[k]));
      vrased_range_chk u_sdata (.addr(dma_addr[16*k +: 16]), .base(SDATA_BASE),
                                .size(SDATA_SIZE), .hit(dma_sdata[k]));
    end
  endgenerate

  always_comb begin
    viol = '0;
    viol[CAUSE_AC]     = data_en && d_kmem && !in_smem;
    viol[CAUSE_XSTACK] = (data_en && d_sdata && !in_smem) ||
                         (data_wr && in_smem && !d_sdata && !d_hmac);
    viol[CAUSE_ENTRY]  = (state_q == ST_IDLE) && in_smem && (pc != SMEM_BASE);
    viol[CAUSE_EXIT]   = (state_q == ST_EXEC) && !in_smem && (pc_prev_q != SMEM_EXIT);
    // An interrupt pending at the exact entry instruction does not spoil a legal entry.
    viol[CAUSE_IRQ]    = irq && in_smem && !((state_q == ST_IDLE) && (pc == SMEM_BASE));
    viol[CAUSE_DMA_KEY]   = |(dma_en & dma_kmem);
    viol[CAUSE_DMA_STACK] = |(dma_en & dma_sdata);
    viol[CAUSE_DMA_EXEC]  = in_smem && (|dma_en);
    dma_bad = dma_en & (dma_kmem | dma_sdata | {N_DMA{in_smem}});
  end

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    dma_src_d    = dma_src_q;
    viol_count_d = viol_count_q;
    hold_cnt_d   = hold_cnt_q;
    pc_prev_d    = pc;
    case (state_q)
      ST_IDLE, ST_EXEC: begin
        if (|viol) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_INIT;
          cause_d    = cause_q | viol;
          dma_src_d  = dma_src_q | dma_bad;
          if (viol_count_q != 8'hFF) viol_count_d = viol_count_q + 8'd1;
        end else if ((state_q == ST_IDLE) && (pc == SMEM_BASE)) begin
          state_d = ST_EXEC;
        end else if ((state_q == ST_EXEC) && !in_smem) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == 4'd0) state_d = ST_WAIT;
        else hold_cnt_d = hold_cnt_q - 4'd1;
      end
      ST_WAIT: begin
        if (pc == RESET_HANDLER) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    reset_d = (state_d == ST_HOLD) || (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      reset_q      <= 1'b0;
      cause_q      <= '0;
      dma_src_q    <= '0;
      viol_count_q <= '0;
      pc_prev_q    <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      reset_q      <= reset_d;
      cause_q      <= cause_d;
      dma_src_q    <= dma_src_d;
      viol_count_q <= viol_count_d;
      pc_prev_q    <= pc_prev_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign reset      = reset_q;
  assign cause      = cause_q;
  assign dma_src    = dma_src_q;
  assign viol_count = viol_count_q;

endmodule

// File: tb/tb_vrased_guard.sv
// tb/tb_vrased_guard.sv - randomized self-checking bench for vrased_guard
// Reference model tracks "running attestation" and "cycles spent in reset" rather than FSM states.
module tb_vrased_guard;

  localparam int N_DMA    = 2;
  localparam int RST_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc, data_addr;
  logic        data_en, data_wr, irq;
  logic [1:0]  dma_en;
  logic [31:0] dma_addr;
  logic        reset;
  logic [7:0]  cause;
  logic [1:0]  dma_src;
  logic [7:0]  viol_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  bit m_run;
  int m_ep, m_prev, m_cause, m_src, m_cnt;

  always #5 clk = ~clk;

  vrased_guard #(.N_DMA(N_DMA), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .data_en(data_en), .data_wr(data_wr),
    .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
    .reset(reset), .cause(cause), .dma_src(dma_src), .viol_count(viol_count)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit in_rgn(input int a, input int base, input int size);
    return (a >= base) && (a <= base + size);
  endfunction

  task automatic model_clear();
    m_run = 0; m_ep = 0; m_prev = 0; m_cause = 0; m_src = 0; m_cnt = 0;
  endtask

  // m_ep: 0 outside an episode, else 1-based count of cycles reset has been high.
  task automatic model_step();
    int v, src, a;
    bit sm;
    if (!reset_n) begin
      model_clear();
      return;
    end
    sm = in_rgn(pc, 'hA000, 'h4000);
    if (m_ep == 0) begin
      v = 0; src = 0;
      if (data_en && in_rgn(data_addr, 'h6A00, 'h1F) && !sm) v |= 1;
      if ((data_en && in_rgn(data_addr, 'h0400, 'h0C00) && !sm) ||
          (data_wr && sm && !in_rgn(data_addr, 'h0400, 'h0C00) && !in_rgn(data_addr, 'h0230, 'h20)))
        v |= 2;
      if (!m_run && sm && pc != 16'hA000) v |= 4;
      if (m_run && !sm && m_prev != 'hDFFE) v |= 8;
      if (irq && sm && !(!m_run && pc == 16'hA000)) v |= 16;
      for (int k = 0; k < N_DMA; k++) begin
        if (dma_en[k]) begin
          a = int'(dma_addr[16*k +: 16]);
          if (in_rgn(a, 'h6A00, 'h1F))   begin v |= 32;  src |= (1 << k); end
          if (in_rgn(a, 'h0400, 'h0C00)) begin v |= 64;  src |= (1 << k); end
          if (sm)                        begin v |= 128; src |= (1 << k); end
        end
      end
      if (v != 0) begin
        m_cause |= v; m_src |= src;
        if (m_cnt < 255) m_cnt++;
        m_ep = 1; m_run = 0;
      end else if (!m_run && pc == 16'hA000) m_run = 1;
      else if (m_run && !sm) m_run = 0;
    end else begin
      if (m_ep > RST_HOLD && pc == 16'h0000) m_ep = 0;
      else m_ep++;
    end
    m_prev = int'(pc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("reset", int'(reset), (m_ep != 0) ? 1 : 0);
      cmp("cause", int'(cause), m_cause);
      cmp("dma_src", int'(dma_src), m_src);
      cmp("viol_count", int'(viol_count), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet(input logic [15:0] p);
    pc = p; data_en = 0; data_wr = 0; data_addr = 16'h0000; irq = 0;
    dma_en = 2'b00; dma_addr = 32'h0;
  endtask

  task automatic do_reset();
    quiet(16'h0000);
    reset_n = 0;
    model_clear();
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic wait_release();
    quiet(16'h0000);
    for (int i = 0; i < 20; i++) begin
      if (!reset) break;
      tick();
    end
    cmp("release_timeout", int'(reset), 0);
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] tbl [0:13];
    tbl = '{16'h6A00, 16'h6A1F, 16'h6A20, 16'h69FF, 16'h03FF, 16'h0400, 16'h1000,
            16'h1001, 16'h022F, 16'h0230, 16'h0250, 16'h0251, 16'h6A10, 16'h0800};
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return tbl[$urandom_range(0, 13)];
  endfunction

  task automatic rand_cycle();
    int r;
    r = $urandom_range(0, 19);
    if (m_ep != 0) pc = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    else if (m_run) begin
      if (pc == 16'hDFFE && r < 14) pc = 16'h5000;
      else if (r < 15) pc = pc + 16'd2;
      else if (r == 15) pc = 16'hDFFE;
      else if (r == 16) pc = 16'hA000;
      else if (r == 17) pc = 16'($urandom);
      else if (r == 18) pc = 16'h5000;
      else pc = 16'hA000 + 16'($urandom_range(0, 'h1FFF) * 2);
    end else begin
      if (r < 8) pc = 16'hA000;
      else if (r < 12) pc = 16'h5000 + 16'($urandom_range(0, 255));
      else pc = 16'($urandom);
    end
    data_en   = ($urandom_range(0, 19) < 2);
    data_wr   = data_en && $urandom_range(0, 1) == 1;
    data_addr = pick_addr();
    irq       = ($urandom_range(0, 29) == 0);
    dma_en[0] = ($urandom_range(0, 24) == 0);
    dma_en[1] = ($urandom_range(0, 24) == 0);
    dma_addr  = {pick_addr(), pick_addr()};
  endtask

  initial begin
    quiet(16'h0000);
    reset_n = 0;
    model_clear();
    chk_en = 1;
    #1;
    cmp("rst_reset", int'(reset), 0);
    cmp("rst_cause", int'(cause), 0);
    cmp("rst_count", int'(viol_count), 0);
    tick();
    reset_n = 1;
    tick();

    // Full legal attestation run, then a legal exit
    quiet(16'hA000); tick();
    for (int p = 'hA002; p <= 'hDFFE; p += 2) begin pc = 16'(p); tick(); end
    pc = 16'h5000; tick(); tick();
    cmp("legal_run_reset", int'(reset), 0);
    cmp("legal_run_cause", int'(cause), 0);

    // Key access from untrusted code; reset high for RST_HOLD HOLD cycles plus one WAIT cycle
    begin
      int hi;
      hi = 0;
      quiet(16'h5000); data_en = 1; data_addr = 16'h6A10; tick();
      cmp("ac_latency", int'(reset), 1);
      quiet(16'h0000);
      for (int i = 0; i < 20; i++) begin
        if (reset) hi++;
        tick();
      end
      cmp("ac_reset_cycles", hi, 5);
      cmp("ac_cause", int'(cause), 8'h01);
      cmp("ac_count", int'(viol_count), 1);
    end

    // DMA into secure stack while executing SW-Att
    do_reset();
    quiet(16'hA000); tick();
    pc = 16'hB000; dma_en = 2'b10; dma_addr = {16'h0500, 16'h0000}; tick();
    cmp("dma_cause", int'(cause), 8'hC0);
    cmp("dma_src", int'(dma_src), 2'b10);
    wait_release();

    // Bad entry, then an ignored violation while waiting
    do_reset();
    quiet(16'h3000); tick();
    pc = 16'hA004; tick();
    cmp("entry_cause", int'(cause), 8'h04);
    pc = 16'h3000;
    for (int i = 0; i < 6; i++) tick();
    data_en = 1; data_addr = 16'h6A00; tick();
    cmp("wait_cause", int'(cause), 8'h04);
    cmp("wait_count", int'(viol_count), 1);
    wait_release();

    // irq at the entry instruction is legal; one instruction later it is not
    do_reset();
    quiet(16'hA000); irq = 1; tick();
    cmp("irq_entry_reset", int'(reset), 0);
    pc = 16'hA002; tick();
    cmp("irq_cause", int'(cause), 8'h10);
    wait_release();

    do_reset();
    pc = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 0;
        model_clear();
        tick();
        reset_n = 1;
      end
      rand_cycle();
      tick();
    end
    wait_release();

    // Saturation, then asynchronous reset in the middle of HOLD
    do_reset();
    for (int i = 0; i < 257; i++) begin
      quiet(16'h5000); data_en = 1; data_addr = 16'h6A10; tick();
      if (i < 256) wait_release();
    end
    cmp("sat_count", int'(viol_count), 8'hFF);
    quiet(16'h5000); tick();
    reset_n = 0;
    model_clear();
    #1;
    cmp("abort_reset", int'(reset), 0);
    cmp("abort_cause", int'(cause), 0);
    cmp("abort_src", int'(dma_src), 0);
    cmp("abort_count", int'(viol_count), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vrased_guard.md
VRASED_GUARD -- requirements
Module: vrased_guard

Interface
REQ-001 Parameter SMEM_BASE, 16'hA000, base address of the attestation code (SW-Att) region.
REQ-002 Parameter SMEM_SIZE, 16'h4000, inclusive end offset of SMEM; the region is [BASE, BASE+SIZE], and the same rule applies to every region.
REQ-003 Parameter SMEM_EXIT, SMEM_BASE+SMEM_SIZE-2, the only legal last-instruction address in SMEM.
REQ-004 Parameter KMEM_BASE / KMEM_SIZE, 16'h6A00 / 16'h001F, key region.
REQ-005 Parameter SDATA_BASE / SDATA_SIZE, 16'h0400 / 16'h0C00, secure stack region.
REQ-006 Parameter HMAC_BASE / HMAC_SIZE, 16'h0230 / 16'h0020, result region writable from SMEM.
REQ-007 Parameter RESET_HANDLER, 16'h0000, PC value that ends a violation.
REQ-008 Parameter N_DMA, 2, DMA channel count, legal range 1..4.
REQ-009 Parameter RST_HOLD, 4, minimum reset assertion in cycles, legal range 1..15.
REQ-010 clk  in  1  system clock; every flop uses its rising edge.
REQ-011 reset_n  in  1  asynchronous, active-low reset.
REQ-012 pc  in  16  current program counter.
REQ-013 data_en / data_wr  in  1 / 1  CPU memory access / write strobe.
REQ-014 data_addr  in  16  CPU data address.
REQ-015 dma_en  in  N_DMA  per-channel DMA active.
REQ-016 dma_addr  in  16*N_DMA  channel k occupies bits [16k+15:16k].
REQ-017 irq  in  1  interrupt taken.
REQ-018 reset  out  1  registered MCU reset request.
REQ-019 cause  out  8  sticky violation bitmask.
REQ-020 dma_src  out  N_DMA  sticky mask of offending DMA channels.
REQ-021 viol_count  out  8  saturating count of violation episodes.

Function
REQ-022 Violation terms are combinational and evaluated every cycle; in_smem is true when pc is in SMEM.
- bit0 AC: data_en, data_addr in KMEM, !in_smem.
- bit1 XSTACK: data_en, data_addr in SDATA, !in_smem; or data_wr, in_smem, data_addr outside SDATA and HMAC.
- bit2 ENTRY: state IDLE, in_smem, pc != SMEM_BASE.
- bit3 EXIT: state EXEC, !in_smem, pc_prev != SMEM_EXIT.
- bit4 IRQ: irq while in_smem.
- bit5 DMA_KEY: any channel enabled with address in KMEM.
- bit6 DMA_STACK: any channel enabled with address in SDATA.
- bit7 DMA_EXEC: any channel enabled while in_smem.
REQ-023 pc_prev is a 16-bit register that loads pc every cycle.
REQ-024 FSM states and transitions:
- IDLE: to EXEC when pc == SMEM_BASE; to HOLD on any violation.
- EXEC: to IDLE when pc legally leaves SMEM; to HOLD on any violation.
- HOLD: reset=1 with a down-counter loaded with RST_HOLD-1; to WAIT at 0.
- WAIT: reset=1; to IDLE when pc == RESET_HANDLER.
REQ-025 Latency: a violation in cycle t drives reset=1 from cycle t+1.
REQ-026 On entry to HOLD, cause is ORed with all active violation bits, and dma_src is ORed with the channels that caused bits 5-7.
REQ-027 On entry to HOLD, viol_count increments by 1 and saturates at 8'hFF.
REQ-028 Violations during HOLD or WAIT are ignored: no cause, dma_src or count update.
REQ-029 Simultaneous violations in one cycle count as one episode with all bits recorded.
REQ-030 reset deasserts in the cycle after WAIT sees pc == RESET_HANDLER, never earlier than RST_HOLD+1 cycles after assertion.
REQ-031 In IDLE, pc == SMEM_BASE is a legal entry even while an irq is pending.

Reset
REQ-032 When reset_n=0: state=IDLE, reset=0, cause=0, dma_src=0, viol_count=0, pc_prev=0, hold counter=0, all asynchronously.
REQ-033 Assertion of reset_n mid-HOLD or mid-WAIT aborts the episode immediately and clears all sticky state.

Structure
REQ-034 Shared package vrased_pkg holds the FSM state encoding, the cause-bit index constants and the default region constants.
REQ-035 One sub-module, vrased_range_chk (addr, base, size -> hit), is instantiated per region and per DMA channel via generate.

Verification
REQ-036 reset_n high, pc=16'hA000, then 16'hA002..16'hDFFE, then 16'h5000 -> state IDLE, reset stays 0, cause=0.
REQ-037 pc=16'h5000, data_en=1, data_addr=16'h6A10 -> reset=1 next cycle for exactly 4 cycles of HOLD, then held until pc=16'h0000, cause=8'h01, viol_count=1.
REQ-038 pc=16'hB000 (in SMEM) with dma_en=2'b10, dma_addr[31:16]=16'h0500 -> cause=8'hC0, dma_src=2'b10.
REQ-039 Jump from pc=16'h3000 directly to 16'hA004 -> cause bit2 set; during WAIT, pulse data_en to 16'h6A00 -> cause unchanged, viol_count unchanged.
REQ-040 Force 256 episodes -> viol_count=8'hFF; then drive reset_n=0 in mid-HOLD -> reset=0 and all outputs 0 in the same cycle.
